// File: rtl/clock_divider_controller_pkg.sv
// Shared clock-domain constants: run-control FSM encoding for divided-clock generators.
// Purely declarative; other clock blocks reuse these encodings.
package clock_divider_controller_pkg;

  typedef enum logic [1:0] {
    CLK_ST_IDLE = 2'd0,
    CLK_ST_RUN  = 2'd1,
    CLK_ST_STOP = 2'd2
  } clk_state_t;

endpackage

// File: rtl/half_period_counter.sv
// Half-period counter: counts up from 0 and flags wrap when count equals limit.
// wrap is combinational from the count register; the count clears on the following edge.
module half_period_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic [WIDTH-1:0] limit,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  // Equality compare lets an all-ones limit give 2^WIDTH cycles without overflow.
  assign wrap = (count == limit);

  always_ff @(posedge clk) begin
    if (rst || clear || wrap) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/clock_divider_controller.sv
// Programmable clock divider with IDLE/RUN/STOP run control and a one-deep config holding slot.
// clk_div/tick are registered; cfg_ready drops while a new half-period waits for a falling boundary.
module clock_divider_controller
  import clock_divider_controller_pkg::*;
#(
  parameter int                   CNT_WIDTH         = 8,
  parameter logic [CNT_WIDTH-1:0] RESET_HALF_PERIOD = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 cfg_valid,
  input  logic [CNT_WIDTH-1:0] cfg_half_period,
  output logic                 cfg_ready,
  output logic                 clk_div,
  output logic                 tick,
  output logic                 running
);

  clk_state_t           state;
  clk_state_t           next_state;
  logic [CNT_WIDTH-1:0] active_hp;
  logic [CNT_WIDTH-1:0] pending_hp;
  logic                 pending_valid;
  logic                 wrap;
  logic                 cnt_clear;
  logic                 to_idle;
  logic                 load_direct;
  logic                 boundary;
  logic                 fall;
  logic                 accept;

  assign accept      = cfg_valid && cfg_ready;
  assign to_idle     = (next_state == CLK_ST_IDLE);
  // A config arriving while idle, or on the way into idle, has no phase to disturb.
  assign load_direct = to_idle || (state == CLK_ST_IDLE);
  assign cnt_clear   = load_direct;
  assign boundary    = wrap && !load_direct;
  assign fall        = boundary && clk_div;

  half_period_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_half_period_counter (
    .clk  (clk),
    .rst  (rst),
    .clear(cnt_clear),
    .limit(active_hp),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLK_ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      CLK_ST_IDLE: begin
        if (enable) next_state = CLK_ST_RUN;
      end
      CLK_ST_RUN: begin
        if (!enable) next_state = clk_div ? CLK_ST_STOP : CLK_ST_IDLE;
      end
      CLK_ST_STOP: begin
        // Hold until the high phase finishes so it is never shortened.
        if (enable) begin
          next_state = CLK_ST_RUN;
        end else if (!clk_div || wrap) begin
          next_state = CLK_ST_IDLE;
        end
      end
      default: next_state = CLK_ST_IDLE;
    endcase
  end

  always_comb begin
    running   = (state != CLK_ST_IDLE);
    cfg_ready = !pending_valid;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div       <= 1'b0;
      tick          <= 1'b0;
      active_hp     <= RESET_HALF_PERIOD;
      pending_hp    <= '0;
      pending_valid <= 1'b0;
    end else begin
      tick <= boundary && !clk_div;

      if (to_idle) begin
        clk_div <= 1'b0;
      end else if (boundary) begin
        clk_div <= !clk_div;
      end

      if (load_direct) begin
        pending_valid <= 1'b0;
        if (accept) begin
          active_hp <= cfg_half_period;
        end else if (pending_valid) begin
          active_hp <= pending_hp;
        end
      end else if (fall && pending_valid) begin
        // New value takes effect from the low phase onward; the high phase stayed on the old one.
        active_hp     <= pending_hp;
        pending_valid <= 1'b0;
      end else if (accept) begin
        pending_hp    <= cfg_half_period;
        pending_valid <= 1'b1;
      end
    end
  end

endmodule

// File: doc/clock_divider_controller.md
CLOCK_DIVIDER_CONTROLLER -- requirements
Module: clock_divider_controller

Interface
REQ-001 Parameter CNT_WIDTH, default 8: width of the half-period configuration and of the internal counter.
REQ-002 Parameter RESET_HALF_PERIOD, default 0: active half-period value loaded at reset (0 = divide-by-2).
REQ-003 clk  input  1  single system clock; all logic is posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  level request to run the divided clock.
REQ-006 cfg_valid  input  1  new half-period offered.
REQ-007 cfg_half_period  input  CNT_WIDTH  requested half-period value; clk_div toggles every value+1 clk cycles.
REQ-008 cfg_ready  output  1  controller can accept a configuration this cycle.
REQ-009 clk_div  output  1  registered divided clock; no combinational path to it.
REQ-010 tick  output  1  one-cycle pulse in the cycle clk_div goes 0->1.
REQ-011 running  output  1  high in RUN and STOP states.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and STOP.
REQ-013 IDLE: clk_div=0, counter=0, tick=0; enable=1 -> RUN in the next cycle.
REQ-014 RUN/STOP: the counter SHALL increment each cycle; when counter==active_hp, the counter SHALL clear and clk_div SHALL toggle (a "boundary").
REQ-015 From RUN entry, the first clk_div rise SHALL occur active_hp+1 cycles later; the period is 2*(active_hp+1) cycles.
REQ-016 The tick output SHALL be asserted in the same cycle the registered clk_div becomes 1, and never otherwise.
REQ-017 RUN with enable=0 and clk_div=0 -> IDLE next cycle.
REQ-018 RUN with enable=0 and clk_div=1 -> STOP.
REQ-019 STOP: the controller SHALL stay in STOP until the falling boundary, then -> IDLE; clk_div SHALL never produce a high phase shorter than active_hp+1 cycles.
REQ-020 STOP with enable=1 -> RUN without disturbing the counter or clk_div.
REQ-021 The configuration handshake SHALL complete on cfg_valid & cfg_ready.
REQ-022 cfg_ready = !pending_valid.
REQ-023 In IDLE, an accepted value SHALL load active_hp directly; pending_valid stays 0.
REQ-024 In RUN/STOP, an accepted value SHALL go to the pending register and set pending_valid.
REQ-025 A pending value SHALL be applied only at a falling boundary (clk_div 1->0) occurring strictly after the acceptance cycle; application clears pending_valid in the same cycle.
REQ-026 If the FSM goes to IDLE with a pending value, that value SHALL be applied on IDLE entry.
REQ-027 Counter comparison SHALL use equality on CNT_WIDTH bits; active_hp = all-ones SHALL give a half-period of 2^CNT_WIDTH cycles with no overflow.
REQ-028 A high or low phase SHALL never mix two half-period values.

Reset
REQ-029 rst SHALL take priority over all inputs and give: state=IDLE, clk_div=0, tick=0, running=0, counter=0, active_hp=RESET_HALF_PERIOD, pending_valid=0, cfg_ready=1.
REQ-030 rst asserted mid-period (including clk_div=1) SHALL force clk_div=0 in the next cycle; a truncated high phase under reset is accepted.

Structure
REQ-031 FSM state encodings (IDLE=0, RUN=1, STOP=2, 2-bit) SHALL live in a shared clock-domain constants package/header, reusable by other clock blocks.
REQ-032 The counter plus its boundary-compare logic SHALL be one sub-module, half_period_counter (inputs clk, rst, clear, limit; output wrap).
REQ-033 The total RTL size SHALL be 120-400 lines.

Verification
REQ-034 Reset, enable=1, hp=0 -> clk_div period 2, tick every 2 cycles; first rise 1 cycle after RUN entry.
REQ-035 In IDLE, cfg hp=3 accepted; enable=1 -> high/low phases of 4 cycles each; tick spacing 8.
REQ-036 Running at hp=3, cfg hp=1 sent mid-high phase -> cfg_ready=0 until the next falling boundary; then phases of 2; no phase of any other length.
REQ-037 enable dropped 1 cycle into a 4-cycle high phase -> STOP, high phase completes (4 cycles), then IDLE, running=0.
REQ-038 enable re-raised during STOP -> back to RUN, period uninterrupted.
REQ-039 CNT_WIDTH=4, hp=15 -> 16-cycle phases; rst pulsed while clk_div=1 -> clk_div=0 next cycle and all outputs at reset values.
